// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, NZCV flag positions,
// controller states and a flag-packing helper.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;

    localparam int FLAG_N = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Place individual flag bits at their architectural positions.
    function automatic logic [3:0] pack_flags(input logic n, input logic c,
                                              input logic z, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/iter_multiplier.sv
// Unsigned shift-add multiplier. The first partial product is formed in the
// start cycle from the incoming operands, so WIDTH iterations take WIDTH
// cycles and o_done pulses with the full 2*WIDTH product already registered.
module iter_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_mc;
    logic [WIDTH-1:0] w_hi_cur;
    logic [WIDTH-1:0] w_lo_cur;
    logic [WIDTH:0]   w_sum;

    // On start the step works on the fresh operands instead of the registers.
    assign w_mc     = i_start ? i_a : r_mcand;
    assign w_hi_cur = i_start ? '0  : r_hi;
    assign w_lo_cur = i_start ? i_b : r_lo;
    assign w_sum    = {1'b0, w_hi_cur} + (w_lo_cur[0] ? {1'b0, w_mc} : '0);

    // One add-and-shift step per cycle; the multiplier bits drain out of r_lo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_mcand <= i_a;
                r_hi    <= w_sum[WIDTH:1];
                r_lo    <= {w_sum[0], w_lo_cur[WIDTH-1:1]};
                r_cnt   <= CW'(1);
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                r_hi  <= w_sum[WIDTH:1];
                r_lo  <= {w_sum[0], w_lo_cur[WIDTH-1:1]};
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done    = r_done;
    assign o_product = {r_hi, r_lo};

endmodule

// File: rtl/seq_alu_core.sv
// Registered ALU with valid/ready on both sides. Single-cycle ops go straight
// from the combinational case into the output register; MUL is handed to the
// iterative multiplier and the controller waits for its done pulse.
module seq_alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags,
    output logic             err
);

    state_e           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic [3:0]       r_flags;
    logic             r_err;

    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [3:0]         w_mul_flags;

    logic [SHW-1:0]   w_s;
    logic [SHW:0]     w_rol_amt;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_err;
    logic [3:0]       w_flags;

    assign w_accept    = in_valid & r_in_ready;
    assign w_mul_start = w_accept & (op == OP_MUL);

    // Shifts carry an extra guard bit so the last bit shifted out lands in it;
    // a zero shift amount leaves the guard bit clear, giving C=0.
    assign w_s       = b[SHW-1:0];
    assign w_rol_amt = (SHW+1)'(WIDTH) - {1'b0, w_s};
    assign w_add     = {1'b0, a} + {1'b0, b};
    assign w_sub     = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    assign w_shl     = {1'b0, a} << w_s;
    assign w_shr     = {a, 1'b0} >> w_s;
    assign w_ror     = (a >> w_s) | (a << w_rol_amt);

    assign w_mul_flags = pack_flags(w_prod[WIDTH-1], |w_prod[2*WIDTH-1:WIDTH],
                                    ~|w_prod[WIDTH-1:0], |w_prod[2*WIDTH-1:WIDTH]);

    // Single-cycle operations; illegal opcodes produce zero data and err.
    always_comb begin
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_err   = 1'b0;
        case (op)
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: w_err = 1'b0;
            OP_OR:  w_res = a | b;
            OP_AND: w_res = a & b;
            OP_XOR: w_res = a ^ b;
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_ROR: begin
                w_res = w_ror;
                w_c   = (w_s != '0) & w_ror[WIDTH-1];
            end
            default: w_err = 1'b1;
        endcase
        w_flags = w_err ? 4'b0000
                        : pack_flags(w_res[WIDTH-1], w_c, (w_res == '0), w_v);
    end

    iter_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_a       (a),
        .i_b       (b),
        .o_done    (w_mul_done),
        .o_product (w_prod)
    );

    // Controller: accept in IDLE, wait for the multiplier in MUL, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (op == OP_MUL) begin
                            r_state <= MUL;
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_result_hi <= '0;
                            r_flags     <= w_flags;
                            r_err       <= w_err;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                MUL: begin
                    if (w_mul_done) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_prod[WIDTH-1:0];
                        r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_flags     <= w_mul_flags;
                        r_err       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign flags     = r_flags;
    assign err       = r_err;

endmodule

// File: tb/tb_seq_alu_core.sv
// Bench for seq_alu_core: a driver issues directed and random operations and
// queues the reference-model answer; a monitor pops and compares whenever the
// core hands over a result.
module tb_seq_alu_core;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [3:0]   flags;
    logic         err;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [3:0]   fl;
        logic         err;
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   stall  = 1'b1;

    seq_alu_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: arithmetic on plain integers, flags in {V,Z,C,N} order.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint M  = longint'(1) << W;
        longint ua = longint'(x);
        longint ub = longint'(y);
        longint sa = (ua >= M / 2) ? ua - M : ua;
        longint sb = (ub >= M / 2) ? ub - M : ub;
        longint r  = 0;
        longint hi = 0;
        longint sr;
        longint p;
        int     s  = int'(ub % W);
        bit     c  = 0;
        bit     v  = 0;
        bit     n;
        bit     z;
        e.err = 1'b0;
        case (o)
            4'd0: begin r = ua + ub; c = (r >= M); r = r % M; sr = sa + sb; v = (sr >= M / 2) || (sr < -M / 2); end
            4'd1: begin r = (ua - ub + M) % M; c = (ua >= ub); sr = sa - sb; v = (sr >= M / 2) || (sr < -M / 2); end
            4'd2: begin p = ua * ub; r = p % M; hi = p / M; c = (hi != 0); v = c; end
            4'd3: r = longint'(x | y);
            4'd4: r = longint'(x & y);
            4'd5: r = longint'(x ^ y);
            4'd6: begin r = (ua * (longint'(1) << s)) % M; c = (s != 0) && (((ua >> (W - s)) & 1) == 1); end
            4'd7: begin r = ua / (longint'(1) << s); c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
            4'd8: begin
                r = ua;
                for (int k = 0; k < s; k++) r = (r >> 1) | ((r & 1) << (W - 1));
                c = (s != 0) && ((r >> (W - 1)) == 1);
            end
            default: e.err = 1'b1;
        endcase
        n     = ((r >> (W - 1)) & 1) == 1;
        z     = (r == 0);
        e.op  = o;
        e.res = r[W-1:0];
        e.hi  = hi[W-1:0];
        e.fl  = e.err ? 4'b0000 : {v, z, c, n};
        e.lat = (o == 4'd2) ? 17 : 1;
        e.acc = 0;
        return e;
    endfunction

    task automatic fail_line(input string name, input longint act, input longint req);
        errors++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            fail_line("accept_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        @(posedge clk);
        #1;
        e     = model(o, x, y);
        e.acc = cyc - 1;
        q.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (q.size() != 0) fail_line("drain_timeout", q.size(), 0);
    endtask

    // Consumer readiness: random backpressure unless a test stalls it.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks latency at each new result and contents at each handover.
    initial begin
        exp_t e;
        bit   prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
                continue;
            end
            if (out_valid && !prev) begin
                checks++;
                if (q.size() == 0) fail_line("unexpected_out_valid", 1, 0);
                else if (cyc - q[0].acc != q[0].lat) fail_line("latency", cyc - q[0].acc, q[0].lat);
            end
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                checks++; if (result    !== e.res) fail_line($sformatf("result op%0d", e.op), result, e.res);
                checks++; if (result_hi !== e.hi)  fail_line($sformatf("result_hi op%0d", e.op), result_hi, e.hi);
                checks++; if (flags     !== e.fl)  fail_line($sformatf("flags op%0d", e.op), flags, e.fl);
                checks++; if (err       !== e.err) fail_line($sformatf("err op%0d", e.op), err, e.err);
            end
            prev = out_valid;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] snap_r, snap_h;
        logic [3:0]   snap_f;
        logic         snap_e;
        logic [W-1:0] ra, rb;
        logic [3:0]   ro;
        bit           seen;
        int           guard;
        logic [W-1:0] edge_vals [5];

        edge_vals[0] = 16'h0000; edge_vals[1] = 16'hFFFF; edge_vals[2] = 16'h8000;
        edge_vals[3] = 16'h7FFF; edge_vals[4] = 16'h0001;

        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, result, result_hi, flags, err} !== '0)
            fail_line("reset_state", {in_ready, out_valid, result, result_hi, flags, err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) fail_line("in_ready_after_reset", in_ready, 1);
        stall = 1'b0;

        // Directed vectors
        send(4'd0, 16'h7FFF, 16'h0001);
        send(4'd1, 16'h0005, 16'h0005);
        send(4'd1, 16'h0003, 16'h0005);
        send(4'd2, 16'h1234, 16'h0100);
        seen = 1'b0; guard = 0;
        while (!out_valid && guard < 40) begin
            if (in_ready) seen = 1'b1;
            @(negedge clk);
            guard++;
        end
        checks++;
        if (seen || !out_valid) fail_line("mul_in_ready_low", seen, 0);
        send(4'd2, 16'hFFFF, 16'hFFFF);
        send(4'd6, 16'h8001, 16'h0001);
        send(4'd8, 16'h0001, 16'h0001);
        send(4'd7, 16'hABCD, 16'h0010);
        send(4'd6, 16'h1234, 16'hFFF4);
        send(4'hB, 16'h1234, 16'h5678);
        drain();

        // Output hold under backpressure
        stall = 1'b1;
        repeat (2) @(negedge clk);
        send(4'd0, 16'h1234, 16'h1111);
        guard = 0;
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        snap_r = result; snap_h = result_hi; snap_f = flags; snap_e = err;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (!out_valid || in_ready || result !== snap_r || result_hi !== snap_h ||
                flags !== snap_f || err !== snap_e)
                fail_line($sformatf("hold_cycle%0d", k), {out_valid, in_ready, result}, {2'b10, snap_r});
        end
        stall = 1'b0;
        drain();

        // Random traffic
        for (int n = 0; n < 150; n++) begin
            ro = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
            send(ro, ra, rb);
        end
        drain();

        // Reset during a multiply must abort it without a stale result
        send(4'd2, 16'h00FF, 16'h0101);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, result, result_hi, flags, err} !== '0)
            fail_line("async_reset_outputs", {in_ready, out_valid, result, result_hi, flags, err}, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) fail_line("stale_out_valid", seen, 0);
        send(4'd0, 16'h0102, 16'h0304);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
